// File: rtl/pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf
//
// Elastic pipeline-stage register for the processor back end (e.g. MEM->WB).
// It carries a control field and a data payload through a DEPTH-entry
// circular buffer with a valid/ready handshake on both sides. A synchronous
// flush turns the stage into a bubble. The hold/wake pair freezes the stage
// during WFI until an interrupt pulse releases it.
//
// Parameters
//   DATA_W  payload width
//   CTRL_W  control-field width (all-zero = bubble)
//   DEPTH   number of buffer entries, any integer >= 1
//   CNT_W   occupancy counter width (derived from DEPTH)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream entry present
//   in_ready   stage accepts an entry this cycle
//   in_ctrl    upstream control field
//   in_data    upstream payload
//   out_valid  head entry presented downstream
//   out_ready  downstream consumes the head this cycle
//   out_ctrl   head control field, 0 when empty
//   out_data   head payload, or the last popped / reset value when empty
//   flush      discard all entries
//   hold       freeze request
//   wake       interrupt pulse, overrides hold for the cycle it is high
//   count      current occupancy
//   full       count == DEPTH
//   empty      count == 0
// ---------------------------------------------------------------------------
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 2,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              hold,
  input  logic              wake,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  // A single-entry buffer still needs a 1-bit pointer so the ports stay legal.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PTR_W-1:0]  rd_ptr_reg,    rd_ptr_next;
  logic [PTR_W-1:0]  wr_ptr_reg,    wr_ptr_next;
  logic [CNT_W-1:0]  count_reg,     count_next;
  logic [DATA_W-1:0] last_data_reg, last_data_next;

  logic [CTRL_W-1:0] ctrl_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic              frozen;
  logic              pop_req;
  logic              push;
  logic              pop;
  logic [CTRL_W-1:0] head_ctrl;
  logic [DATA_W-1:0] head_data;

  // Pointer advance with an explicit wrap compare, so non-power-of-two
  // depths return to entry 0 instead of running into unused indices.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
  endfunction

  // -------------------------------------------------------------------------
  // Handshake and status
  // -------------------------------------------------------------------------
  assign frozen = hold & ~wake;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == DEPTH_CNT);
  assign count = count_reg;

  assign out_valid = ~empty & ~frozen;
  assign pop_req   = out_valid & out_ready;

  // The pop term lets a full buffer accept a new entry in the cycle its head
  // leaves; for DEPTH = 1 this is the only way to stream at one per cycle.
  assign in_ready = rst_n & ~flush & ~frozen & (~full | pop_req);

  assign push = in_valid & in_ready;
  // Flush wins over a consumer that happens to be ready in the same cycle.
  assign pop  = pop_req & ~flush;

  assign head_ctrl = ctrl_mem[rd_ptr_reg];
  assign head_data = data_mem[rd_ptr_reg];

  assign out_ctrl = empty ? '0 : head_ctrl;
  // When empty the payload shows the last value that actually left the
  // stage (zero after reset), not whatever stale word the read pointer hits.
  assign out_data = empty ? last_data_reg : head_data;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    rd_ptr_next    = rd_ptr_reg;
    wr_ptr_next    = wr_ptr_reg;
    count_next     = count_reg;
    last_data_next = last_data_reg;

    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      // While frozen both push and pop are already forced low, so the
      // buffer simply keeps its contents.
      if (pop) begin
        rd_ptr_next    = ptr_inc(rd_ptr_reg);
        last_data_next = head_data;
      end
      if (push) begin
        wr_ptr_next = ptr_inc(wr_ptr_reg);
      end
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      last_data_reg <= '0;
    end else begin
      rd_ptr_reg    <= rd_ptr_next;
      wr_ptr_reg    <= wr_ptr_next;
      count_reg     <= count_next;
      last_data_reg <= last_data_next;
    end
  end

  // -------------------------------------------------------------------------
  // Storage: one write-enabled register per entry. Contents need no reset
  // because nothing reads an entry until it has been pushed.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic wr_en;
      assign wr_en = push & (wr_ptr_reg == PTR_W'(gi));

      always_ff @(posedge clk) begin
        if (wr_en) begin
          ctrl_mem[gi] <= in_ctrl;
          data_mem[gi] <= in_data;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_buf
//
// Drives a DEPTH=2 and a DEPTH=3 instance with the same stimulus and compares
// every output, every cycle, against a queue-style reference model (index 0
// is always the head; entries shift down on a pop).
// ---------------------------------------------------------------------------
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic [1:0]  in_ctrl;
  logic [31:0] in_data;
  logic        out_ready;
  logic        flush;
  logic        hold;
  logic        wake;

  logic        in_ready_o  [2];
  logic        out_valid_o [2];
  logic [1:0]  out_ctrl_o  [2];
  logic [31:0] out_data_o  [2];
  logic [1:0]  count_o     [2];
  logic        full_o      [2];
  logic        empty_o     [2];

  pipe_stage_buf #(.DATA_W(32), .CTRL_W(2), .DEPTH(2)) u_d2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_o[0]),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid_o[0]), .out_ready(out_ready),
    .out_ctrl(out_ctrl_o[0]), .out_data(out_data_o[0]),
    .flush(flush), .hold(hold), .wake(wake),
    .count(count_o[0]), .full(full_o[0]), .empty(empty_o[0])
  );

  pipe_stage_buf #(.DATA_W(32), .CTRL_W(2), .DEPTH(3)) u_d3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_o[1]),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid_o[1]), .out_ready(out_ready),
    .out_ctrl(out_ctrl_o[1]), .out_data(out_data_o[1]),
    .flush(flush), .hold(hold), .wake(wake),
    .count(count_o[1]), .full(full_o[1]), .empty(empty_o[1])
  );

  // Reference model state
  int          dep   [2] = '{2, 3};
  logic [33:0] mq    [2][4];
  int          mcnt  [2];
  logic [31:0] mlast [2];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mcnt[k]  = 0;
      mlast[k] = '0;
    end
  endtask

  // Compare all outputs of both instances with the model for the current inputs.
  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      bit frz, pop_ok, rdy;
      string p;
      p      = $sformatf("d%0d", dep[k]);
      frz    = hold && !wake;
      pop_ok = !frz && (mcnt[k] > 0) && out_ready;
      rdy    = rst_n && !flush && !frz && ((mcnt[k] < dep[k]) || pop_ok);
      chk({p, "_in_ready"},  64'(in_ready_o[k]),  64'(rdy));
      chk({p, "_out_valid"}, 64'(out_valid_o[k]), 64'((mcnt[k] > 0) && !frz));
      chk({p, "_out_ctrl"},  64'(out_ctrl_o[k]),  64'((mcnt[k] > 0) ? mq[k][0][33:32] : 2'b00));
      chk({p, "_out_data"},  64'(out_data_o[k]),  64'((mcnt[k] > 0) ? mq[k][0][31:0] : mlast[k]));
      chk({p, "_count"},     64'(count_o[k]),     64'(mcnt[k]));
      chk({p, "_full"},      64'(full_o[k]),      64'(mcnt[k] == dep[k]));
      chk({p, "_empty"},     64'(empty_o[k]),     64'(mcnt[k] == 0));
    end
  endtask

  // Apply one clock edge to the model using the inputs held across that edge.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      bit frz, do_pop, do_push;
      frz     = hold && !wake;
      do_pop  = !frz && !flush && (mcnt[k] > 0) && out_ready;
      do_push = in_valid && !flush && !frz && ((mcnt[k] < dep[k]) || do_pop);
      if (flush) begin
        mcnt[k] = 0;
      end else begin
        if (do_pop) begin
          mlast[k] = mq[k][0][31:0];
          for (int j = 0; j < 3; j++) mq[k][j] = mq[k][j+1];
          mcnt[k]--;
        end
        if (do_push) begin
          mq[k][mcnt[k]] = {in_ctrl, in_data};
          mcnt[k]++;
        end
      end
    end
  endtask

  task automatic step(input bit iv, input logic [1:0] c, input logic [31:0] d,
                      input bit ordy, input bit fl, input bit hd, input bit wk);
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    hold      = hd;
    wake      = wk;
    #3;
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 0; in_ctrl = 0; in_data = 0;
    out_ready = 0; flush = 0; hold = 0; wake = 0;
    model_reset();
    #3;
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset and stream: one-cycle latency, occupancy never above 1
    step(1, 2'd1, 32'hA, 1, 0, 0, 0);
    chk("stream_a_data", 64'(out_data_o[0]), 64'h0A);
    chk("stream_a_cnt",  64'(count_o[0]),    64'd1);
    step(1, 2'd2, 32'hB, 1, 0, 0, 0);
    chk("stream_b_data", 64'(out_data_o[0]), 64'h0B);
    chk("stream_b_ctrl", 64'(out_ctrl_o[0]), 64'd2);
    step(1, 2'd3, 32'hC, 1, 0, 0, 0);
    chk("stream_c_data", 64'(out_data_o[0]), 64'h0C);
    chk("stream_c_cnt",  64'(count_o[0]),    64'd1);
    step(0, 2'd0, 32'h0, 1, 0, 0, 0);
    chk("stream_drain",  64'(empty_o[0]),    64'd1);

    // Back-pressure: fill, then push and pop together through wrap-around
    for (int i = 0; i < 4; i++) step(1, 2'(i + 1), 32'h100 + i, 0, 0, 0, 0);
    chk("bp_full3",  64'(full_o[1]),  64'd1);
    chk("bp_count3", 64'(count_o[1]), 64'd3);
    chk("bp_full2",  64'(full_o[0]),  64'd1);
    in_valid = 1; out_ready = 0; #1;
    chk("bp_ready3", 64'(in_ready_o[1]), 64'd0);
    for (int i = 0; i < 6; i++) begin
      step(1, 2'(i % 3 + 1), $urandom, 1, 0, 0, 0);
      chk("bp_steady3", 64'(count_o[1]), 64'd3);
    end

    // Flush collision with a push and a pop in the same cycle
    step(0, 2'd0, 32'h0, 0, 1, 0, 0);
    step(1, 2'd1, 32'h201, 0, 0, 0, 0);
    step(1, 2'd2, 32'h202, 0, 0, 0, 0);
    step(1, 2'd3, 32'hDEAD, 1, 1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("fl_count_d%0d", dep[k]), 64'(count_o[k]),    64'd0);
      chk($sformatf("fl_empty_d%0d", dep[k]), 64'(empty_o[k]),    64'd1);
      chk($sformatf("fl_ctrl_d%0d",  dep[k]), 64'(out_ctrl_o[k]), 64'd0);
    end
    step(0, 2'd0, 32'h0, 1, 0, 0, 0);

    // Hold for 5 cycles, then a wake pulse pops the head
    step(1, 2'd1, 32'h55, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 2'd2, 32'h77, 1, 0, 1, 0);
      chk("hold_count", 64'(count_o[1]),     64'd1);
      chk("hold_valid", 64'(out_valid_o[1]), 64'd0);
    end
    step(0, 2'd0, 32'h0, 1, 0, 1, 1);
    chk("wake_pop_cnt",  64'(count_o[1]),    64'd0);
    chk("wake_pop_data", 64'(out_data_o[1]), 64'h55);
    step(0, 2'd0, 32'h0, 1, 0, 0, 0);

    // Randomised traffic, including occasional flush / hold / wake
    for (int i = 0; i < 80; i++) begin
      step(bit'($urandom_range(0, 1)), 2'($urandom), $urandom,
           bit'($urandom_range(0, 3) != 0),
           bit'($urandom_range(0, 15) == 0),
           bit'($urandom_range(0, 7) == 0),
           bit'($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset between edges with two entries queued
    step(0, 2'd0, 32'h0, 0, 1, 0, 0);
    step(1, 2'd1, 32'h301, 0, 0, 0, 0);
    step(1, 2'd2, 32'h302, 0, 0, 0, 0);
    in_valid = 0;
    chk("pre_rst_count", 64'(count_o[1]), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("arst_valid_d%0d", dep[k]), 64'(out_valid_o[k]), 64'd0);
      chk($sformatf("arst_count_d%0d", dep[k]), 64'(count_o[k]),     64'd0);
      chk($sformatf("arst_data_d%0d",  dep[k]), 64'(out_data_o[k]),  64'd0);
      chk($sformatf("arst_ready_d%0d", dep[k]), 64'(in_ready_o[k]),  64'd0);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 2'd3, 32'h401, 1, 0, 0, 0);
    step(0, 2'd0, 32'h0, 1, 0, 0, 0);
    step(0, 2'd0, 32'h0, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline-stage register that replaces the fixed single-entry stage latches between the processor's back-end stages, such as MEM→WB. It carries a control field and a data payload through a DEPTH-entry elastic buffer with a valid/ready handshake. It supports a synchronous flush that turns the stage into a bubble, and a hold/wake pair that freezes the stage during WFI until an interrupt wakes it. Previously, a stalled stage could only freeze; with DEPTH > 1 it now absorbs back-pressure without stalling upstream.

## Interface
- DATA_W, 32, payload width (ALU result, load data, CSR result concatenated by instantiator)
- CTRL_W, 2, control-field width (write-back enables); all-zero = bubble
- DEPTH, 2, buffer entries, any integer ≥ 1 (non-power-of-two allowed)
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage accepts entry this cycle
- in_ctrl  in  CTRL_W  upstream control field
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  head entry presented downstream
- out_ready  in  1  downstream consumes head this cycle
- out_ctrl  out  CTRL_W  head control field; 0 when empty
- out_data  out  DATA_W  head payload
- flush  in  1  discard all entries (branch/trap redirect)
- hold  in  1  freeze request (WFI)
- wake  in  1  interrupt pulse; overrides hold
- count  out  CNT_W  current occupancy
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- frozen = hold & ~wake.
- Pop occurs when out_valid & out_ready. Push occurs when in_valid & in_ready.
- in_ready = rst_n & ~flush & ~frozen & (~full | pop). The combinational pop term lets a full buffer push and pop in the same cycle.
- out_valid = ~empty & ~frozen. out_ctrl = empty ? 0 : head ctrl. out_data = head data; when empty it shows the last popped or reset value.
- Storage is a circular buffer with rd_ptr, wr_ptr and count. Each pointer wraps to 0 when it would reach DEPTH, using an explicit compare, not a bit truncation.
- count_next = count + push − pop. It never exceeds DEPTH and never goes below 0.
- Priority, highest first: reset > flush > frozen > normal.
- Flush:
  - Next cycle: count = 0 and rd_ptr = wr_ptr = 0.
  - Same cycle: no push and no pop occur, and any in_valid entry is dropped.
  - Flush while frozen still clears the buffer.
- Frozen: pointers, count and storage are unchanged. out_valid reads 0 and in_ready reads 0. Contents reappear unchanged once hold falls or wake pulses.
- Wake: for the cycle it is high, the stage behaves as normal even while hold stays high.
- Reset mid-operation: all contents are lost immediately (asynchronous). Outputs take their reset values within the same cycle.

## Timing
- Reset values:
  - out_valid 0, out_ctrl 0, out_data 0, count 0, full 0, empty 1
  - in_ready 0 while rst_n is low; 1 in the first cycle after release (absent flush or hold)
  - rd_ptr 0, wr_ptr 0
- Latency: an entry pushed at edge N appears on out_valid/out_ctrl/out_data after edge N, i.e. one cycle. There is no combinational in→out data path.
- Full throughput: with out_ready held at 1, one entry per cycle passes with one-cycle latency at any DEPTH.
- DEPTH = 1: the block is equivalent to a single latch with handshake. It sustains full throughput only through the pop term in in_ready.
- Handshake rules:
  - in_ctrl and in_data are sampled only on push.
  - Upstream may drop in_valid at any time; there is no hold-until-accept requirement on the producer.
  - Downstream must not take an entry unless out_valid is 1.
- full/empty/count reflect registered state after the edge. They do not anticipate same-cycle push or pop.

## Test plan
- Reset and stream:
  - Stimulus: DEPTH=2. Assert rst_n=0, release it, then push 0xA, 0xB, 0xC on consecutive cycles with out_ready=1.
  - Response: out_data is 0xA, 0xB, 0xC one cycle after each push, out_ctrl matches, and count stays ≤ 1.
- Back-pressure and full:
  - Stimulus: DEPTH=3, out_ready=0, push 4 entries.
  - Response: the first 3 are accepted and full=1. Then in_ready=0 and count=3.
  - Next, raise out_ready while pushing.
  - Response: one pop and one push per cycle, count stays 3, and FIFO order is preserved through wrap-around.
- Flush collision:
  - Stimulus: count=2, and flush, in_valid and out_ready all high in the same cycle.
  - Response: next cycle count=0, empty=1 and out_ctrl=0. The incoming entry never appears.
- Hold/wake:
  - Stimulus: count=1 with head 0x55, then hold=1 for 5 cycles.
  - Response: out_valid=0, in_ready=0 and count=1 throughout.
  - Next, pulse wake for 1 cycle with out_ready=1.
  - Response: 0x55 pops that cycle.
- Non-power-of-two:
  - Stimulus: DEPTH=3, run 10 randomised push/pop cycles.
  - Response: pointers wrap 2→0 and no entry is lost or duplicated, checked against a reference queue.
- Async reset mid-stream:
  - Stimulus: drop rst_n between edges while count=2.
  - Response: out_valid=0, count=0 and out_data=0 immediately, before the next edge.
